// File: rtl/rr_mux4_sel_arbiter_if.sv
// Bundle between the four requester agents and the round-robin arbiter
// that steers a shared 4:1 mux. The master side raises requests; the
// slave side (the arbiter) returns the registered grant and mux select.
interface rr_mux4_sel_arbiter_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       req;
    logic [3:0]       gnt;
    logic [1:0]       ctrl_sel;
    logic             sel_valid;
    logic [CNT_W-1:0] hold_cnt;

    modport master (
        output req,
        input  gnt,
        input  ctrl_sel,
        input  sel_valid,
        input  hold_cnt
    );

    modport slave (
        input  req,
        output gnt,
        output ctrl_sel,
        output sel_valid,
        output hold_cnt
    );
endinterface

// File: rtl/rr_mux4_sel_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux.
// A requester keeps the mux for up to MAX_HOLD consecutive cycles while
// others wait; on release the pointer moves past the old owner and a new
// winner is granted at the same edge, so tenures hand off without a bubble.
// Every output comes straight from a register.
module rr_mux4_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    rr_mux4_sel_arbiter_if.slave        arb
);
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [3:0]       gnt_q,   gnt_d;
    logic [1:0]       sel_q,   sel_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [3:0] others;
    logic       release_own;
    logic [3:0] scan_req;
    logic [1:0] scan_base;
    logic       win_found;
    logic [1:0] win_idx;

    // First set bit of r scanning base, base+1, ... modulo 4.
    function automatic logic [2:0] pick_first(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Scan from the far end so the closest candidate overwrites last.
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Winner search: from ptr while idle, or over the non-owner requests
    // starting just past the owner when a tenure may end.
    always_comb begin
        others      = arb.req & ~(4'b0001 << sel_q);
        release_own = !arb.req[sel_q] || ((cnt_q == HOLD_MAX) && (|others));
        if (state_q == OWN) begin
            scan_req  = others;
            scan_base = sel_q + 2'd1;
        end else begin
            scan_req  = arb.req;
            scan_base = ptr_q;
        end
        {win_found, win_idx} = pick_first(scan_req, scan_base);
    end

    // Next-state and next-output logic for the IDLE/OWN machine.
    always_comb begin
        // NOTE: every target gets a hold-value default first so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = OWN;
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    valid_d = 1'b1;
                    cnt_d   = CNT_ONE;
                end
            end
            OWN: begin
                if (release_own) begin
                    ptr_d = scan_base;
                    if (win_found) begin
                        gnt_d   = 4'b0001 << win_idx;
                        sel_d   = win_idx;
                        cnt_d   = CNT_ONE;
                    end else begin
                        // ctrl_sel keeps pointing at the last owner while idle.
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q < HOLD_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.ctrl_sel  = sel_q;
    assign arb.sel_valid = valid_q;
    assign arb.hold_cnt  = cnt_q;
endmodule

// File: tb/tb_rr_mux4_sel_arbiter.sv
// Bench for rr_mux4_sel_arbiter: two instances (MAX_HOLD=8 and 2) share
// one request stream. Directed tables and sequences check fixed expected
// values; a tenure-level reference model checks every cycle throughout.
module tb_rr_mux4_sel_arbiter;
    logic       clk;
    logic       rst;
    logic [3:0] req_drv;
    logic [3:0] data_in;
    logic       data_out8;

    rr_mux4_sel_arbiter_if #(.CNT_W(8)) bus8 ();
    rr_mux4_sel_arbiter_if #(.CNT_W(8)) bus2 ();

    assign bus8.req = req_drv;
    assign bus2.req = req_drv;

    rr_mux4_sel_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .arb (bus8)
    );

    rr_mux4_sel_arbiter #(.MAX_HOLD(2), .CNT_W(8)) dut2 (
        .clk (clk),
        .rst (rst),
        .arb (bus2)
    );

    // Behavioural 4:1 mux fed by the arbiter select.
    assign data_out8 = data_in[bus8.ctrl_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit en_model = 1'b0;

    // Tenure-level reference: who owns the mux, for how long, and who is next.
    typedef struct {
        int owner;   // -1 when idle
        int ptr;
        int cnt;
        int sel;
    } model_t;

    model_t m8, m2;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic [7:0] cnt;
    } vec_t;

    function automatic int scan(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic model_t model_step(input model_t m, input logic [3:0] r,
                                          input logic rst_i, input int maxh);
        model_t     n;
        int         w;
        logic [3:0] rest;
        n = m;
        if (rst_i) begin
            n.owner = -1; n.ptr = 0; n.cnt = 0; n.sel = 0;
            return n;
        end
        if (m.owner < 0) begin
            w = scan(r, m.ptr);
            if (w >= 0) begin
                n.owner = w; n.sel = w; n.cnt = 1;
            end
        end else begin
            rest = r;
            rest[m.owner] = 1'b0;
            if (!r[m.owner] || (m.cnt == maxh && rest != 4'b0)) begin
                n.ptr = (m.owner + 1) % 4;
                w = scan(rest, n.ptr);
                if (w >= 0) begin
                    n.owner = w; n.sel = w; n.cnt = 1;
                end else begin
                    n.owner = -1; n.cnt = 0;
                end
            end else if (m.cnt < maxh) begin
                n.cnt = m.cnt + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m8 <= model_step(m8, req_drv, rst, 8);
        m2 <= model_step(m2, req_drv, rst, 2);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model(input string tag, input model_t m, input logic [3:0] g,
                               input logic [1:0] s, input logic v, input logic [7:0] c);
        check({tag, " gnt"},       32'(g), (m.owner < 0) ? 32'd0 : (32'd1 << m.owner));
        check({tag, " ctrl_sel"},  32'(s), 32'(m.sel));
        check({tag, " sel_valid"}, 32'(v), (m.owner >= 0) ? 32'd1 : 32'd0);
        check({tag, " hold_cnt"},  32'(c), 32'(m.cnt));
    endtask

    // Advance one clock; outputs are examined at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (en_model) begin
            check_model("model8", m8, bus8.gnt, bus8.ctrl_sel, bus8.sel_valid, bus8.hold_cnt);
            check_model("model2", m2, bus2.gnt, bus2.ctrl_sel, bus2.sel_valid, bus2.hold_cnt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_drv = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vec_t rot[9];
        int   exp_seq[4];

        rst     = 1'b1;
        req_drv = 4'b1111;
        data_in = 4'b1010;

        // Reset held two cycles with every request raised.
        tick();
        tick();
        check("reset gnt8",   32'(bus8.gnt),       32'd0);
        check("reset sel8",   32'(bus8.ctrl_sel),  32'd0);
        check("reset valid8", 32'(bus8.sel_valid), 32'd0);
        check("reset cnt8",   32'(bus8.hold_cnt),  32'd0);
        check("reset gnt2",   32'(bus2.gnt),       32'd0);
        check("reset cnt2",   32'(bus2.hold_cnt),  32'd0);
        en_model = 1'b1;

        // Rotation with everyone requesting, MAX_HOLD=2.
        rot[0] = '{4'b1111, 4'b0001, 2'd0, 1'b1, 8'd1};
        rot[1] = '{4'b1111, 4'b0001, 2'd0, 1'b1, 8'd2};
        rot[2] = '{4'b1111, 4'b0010, 2'd1, 1'b1, 8'd1};
        rot[3] = '{4'b1111, 4'b0010, 2'd1, 1'b1, 8'd2};
        rot[4] = '{4'b1111, 4'b0100, 2'd2, 1'b1, 8'd1};
        rot[5] = '{4'b1111, 4'b0100, 2'd2, 1'b1, 8'd2};
        rot[6] = '{4'b1111, 4'b1000, 2'd3, 1'b1, 8'd1};
        rot[7] = '{4'b1111, 4'b1000, 2'd3, 1'b1, 8'd2};
        rot[8] = '{4'b1111, 4'b0001, 2'd0, 1'b1, 8'd1};
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            req_drv = rot[i].req;
            tick();
            check($sformatf("rot%0d gnt", i),   32'(bus2.gnt),       32'(rot[i].gnt));
            check($sformatf("rot%0d sel", i),   32'(bus2.ctrl_sel),  32'(rot[i].sel));
            check($sformatf("rot%0d valid", i), 32'(bus2.sel_valid), 32'(rot[i].valid));
            check($sformatf("rot%0d cnt", i),   32'(bus2.hold_cnt),  32'(rot[i].cnt));
        end

        // Lone requester 2 with MAX_HOLD=8: saturation, then release to idle.
        do_reset();
        req_drv = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("solo gnt c%0d", k), 32'(bus8.gnt),      32'h4);
            check($sformatf("solo sel c%0d", k), 32'(bus8.ctrl_sel), 32'd2);
            check($sformatf("solo cnt c%0d", k), 32'(bus8.hold_cnt), (k < 8) ? 32'(k) : 32'd8);
        end
        req_drv = 4'b0000;
        tick();
        check("solo drop gnt",   32'(bus8.gnt),       32'd0);
        check("solo drop valid", 32'(bus8.sel_valid), 32'd0);
        check("solo drop cnt",   32'(bus8.hold_cnt),  32'd0);
        check("solo drop sel",   32'(bus8.ctrl_sel),  32'd2);

        // Owner 1 drops while 0 and 3 arrive: scan from 2 picks 3, no bubble.
        do_reset();
        req_drv = 4'b0010;
        tick();
        tick();
        check("handoff pre gnt", 32'(bus8.gnt), 32'h2);
        req_drv = 4'b1001;
        tick();
        check("handoff gnt8", 32'(bus8.gnt),      32'h8);
        check("handoff sel8", 32'(bus8.ctrl_sel), 32'd3);
        check("handoff cnt8", 32'(bus8.hold_cnt), 32'd1);
        check("handoff gnt2", 32'(bus2.gnt),      32'h8);

        // Reset in the middle of a tenure clears the pointer as well.
        do_reset();
        req_drv = 4'b0100;
        for (int k = 0; k < 5; k++) tick();
        check("midrst cnt before", 32'(bus8.hold_cnt), 32'd5);
        rst = 1'b1;
        req_drv = 4'b0101;
        tick();
        check("midrst gnt during", 32'(bus8.gnt), 32'd0);
        rst = 1'b0;
        tick();
        check("midrst gnt after", 32'(bus8.gnt),      32'h1);
        check("midrst sel after", 32'(bus8.ctrl_sel), 32'd0);

        // End-to-end through the mux: each requester holds for 3 cycles.
        exp_seq = '{0, 1, 0, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_drv = 4'b0001 << i;
            for (int k = 0; k < 3; k++) begin
                tick();
                check($sformatf("mux r%0d valid", i), 32'(bus8.sel_valid), 32'd1);
                check($sformatf("mux r%0d data", i),  32'(data_out8),      32'(exp_seq[i]));
            end
        end

        // Randomised traffic against the reference model.
        req_drv = 4'b0000;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ((c / 400) % 2 == 1) begin
                // Sparse phase: mostly single requesters held for long stretches.
                if ($urandom_range(0, 11) == 0)
                    req_drv = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                                          : (4'b0001 << $urandom_range(0, 3));
            end else if ($urandom_range(0, 3) == 0) begin
                req_drv = 4'($urandom_range(0, 15));
            end
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
